// File: rtl/keccak_lane_io_if.sv
// rtl/keccak_lane_io_if.sv - host command/lane streams and state-memory port of keccak_lane_io
interface keccak_lane_io_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  cmd_valid;
  logic [1:0]            cmd;
  logic                  cmd_ready;
  logic                  done;
  logic                  in_valid;
  logic [63:0]           in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [63:0]           out_data;
  logic                  out_ready;
  logic                  mem_enR;
  logic                  mem_enW;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [63:0]           mem_wdata;
  logic [63:0]           mem_rdata;

  modport slave (
    input  cmd_valid, cmd, in_valid, in_data, out_ready, mem_rdata,
    output cmd_ready, done, in_ready, out_valid, out_data,
           mem_enR, mem_enW, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd, in_valid, in_data, out_ready, mem_rdata,
    input  cmd_ready, done, in_ready, out_valid, out_data,
           mem_enR, mem_enW, mem_addr, mem_wdata
  );
endinterface

// File: rtl/keccak_lane_io.sv
// rtl/keccak_lane_io.sv - lane-serial clear/absorb/squeeze port in front of the Keccak state memory
module keccak_lane_io #(
  parameter int RATE_LANES = 17,
  parameter int ADDR_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  keccak_lane_io_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, CLR, ABS_WAIT, ABS_RD, ABS_WR, SQZ_RD, SQZ_CAP, SQZ_OUT, DONE
  } state_t;

  localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0] LAST_LANE = 5'd24;

  state_t      state;
  state_t      state_next;
  logic [4:0]  idx;
  logic [63:0] lane_reg;
  logic [63:0] out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            2'b00:   state_next = CLR;
            2'b01:   state_next = ABS_WAIT;
            2'b10:   state_next = SQZ_RD;
            default: state_next = IDLE;
          endcase
        end
      end
      CLR:      if (idx == LAST_LANE) state_next = DONE;
      ABS_WAIT: if (bus.in_valid) state_next = ABS_RD;
      ABS_RD:   state_next = ABS_WR;
      ABS_WR:   state_next = (idx == LAST_RATE) ? DONE : ABS_WAIT;
      SQZ_RD:   state_next = SQZ_CAP;
      SQZ_CAP:  state_next = SQZ_OUT;
      SQZ_OUT: begin
        if (bus.out_ready) begin
          state_next = (idx == LAST_RATE) ? DONE : SQZ_RD;
        end
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // idx saturates at the last lane of each phase so it never leaves 0..24
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      lane_reg   <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        IDLE:     if (bus.cmd_valid) idx <= '0;
        CLR:      if (idx != LAST_LANE) idx <= idx + 5'd1;
        ABS_WAIT: if (bus.in_valid) lane_reg <= bus.in_data;
        ABS_WR:   if (idx != LAST_RATE) idx <= idx + 5'd1;
        SQZ_CAP:  out_data_q <= bus.mem_rdata;
        SQZ_OUT:  if (bus.out_ready && idx != LAST_RATE) idx <= idx + 5'd1;
        default:  ;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.in_ready  = (state == ABS_WAIT);
  assign bus.out_valid = (state == SQZ_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.mem_enR   = (state == ABS_RD) || (state == SQZ_RD);
  assign bus.mem_enW   = (state == CLR) || (state == ABS_WR);
  assign bus.mem_addr  = ADDR_WIDTH'(idx);
  // clear writes zero; only the absorb write carries data
  assign bus.mem_wdata = (state == ABS_WR) ? (lane_reg ^ bus.mem_rdata) : 64'd0;

endmodule
